// File: rtl/imem_loader.sv
// Writable instruction memory with a byte-stream program loader.
// The CPU fetch port reads combinationally in RUN and stalls while a program is loaded.
module imem_loader #(
  parameter int unsigned N  = 32,
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  output logic [N-1:0]  cpu_q,
  output logic          cpu_stall,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [7:0]    load_byte,
  input  logic          load_end,
  output logic          load_ready,
  output logic          load_done,
  output logic [AW:0]   word_count
);

  localparam int unsigned NB    = N / 8;
  localparam int unsigned BW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {RUN, LOAD, FLUSH} state_t;

  state_t        state;
  logic [N-1:0]  mem [DEPTH];
  logic [N-1:0]  asm_q;
  logic [N-1:0]  asm_next;
  logic [BW-1:0] byte_idx;
  logic [AW-1:0] waddr;
  logic          xfer;
  logic          last_byte;

  assign xfer      = load_valid && load_ready;
  assign last_byte = (byte_idx == BW'(NB - 1));

  // Assembly register with the incoming byte merged into its lane
  always_comb begin
    asm_next = asm_q;
    if (xfer) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (BW'(b) == byte_idx) asm_next[8*b +: 8] = load_byte;
      end
    end
  end

  // Fetch port is zero-latency; the core sees zeros while the memory is owned by the loader
  assign cpu_q = (state == RUN) ? mem[cpu_addr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      asm_q      <= '0;
      byte_idx   <= '0;
      waddr      <= '0;
      word_count <= '0;
      cpu_stall  <= 1'b0;
      load_ready <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (load_start) begin
            state      <= LOAD;
            asm_q      <= '0;
            byte_idx   <= '0;
            waddr      <= '0;
            word_count <= '0;
            cpu_stall  <= 1'b1;
            load_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer && last_byte) begin
            mem[waddr] <= asm_next;
            waddr      <= waddr + AW'(1);
            word_count <= word_count + (AW+1)'(1);
            byte_idx   <= '0;
            asm_q      <= '0;
            // No wrap-around: a full memory ends the load just like load_end
            if (load_end || waddr == AW'(DEPTH - 1)) begin
              state      <= FLUSH;
              load_ready <= 1'b0;
              load_done  <= 1'b1;
            end
          end else if (load_end) begin
            if (xfer || byte_idx != '0) begin
              mem[waddr] <= asm_next;
              waddr      <= waddr + AW'(1);
              word_count <= word_count + (AW+1)'(1);
            end
            byte_idx   <= '0;
            asm_q      <= '0;
            state      <= FLUSH;
            load_ready <= 1'b0;
            load_done  <= 1'b1;
          end else if (xfer) begin
            asm_q    <= asm_next;
            byte_idx <= byte_idx + BW'(1);
          end
        end
        FLUSH: begin
          state     <= RUN;
          load_done <= 1'b0;
          cpu_stall <= 1'b0;
        end
        default: begin
          state      <= RUN;
          cpu_stall  <= 1'b0;
          load_ready <= 1'b0;
          load_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of expected memory words per phase
// plus hand-written load sequences for the multi-cycle corners.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic [5:0]  cpu_addr;
  logic [31:0] cpu_q;
  logic        cpu_stall;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_end;
  logic        load_ready;
  logic        load_done;
  logic [6:0]  word_count;

  int n_cmp;
  int n_bad;

  typedef struct {
    int          phase;
    logic [5:0]  addr;
    logic [31:0] q;
  } vec_t;

  vec_t vecs[15];

  imem_loader #(.N(32), .AW(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_q      (cpu_q),
    .cpu_stall  (cpu_stall),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_end   (load_end),
    .load_ready (load_ready),
    .load_done  (load_done),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic e);
    load_valid = 1'b1;
    load_byte  = b;
    load_end   = e;
    tick();
    load_valid = 1'b0;
    load_end   = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic check_phase(input int p);
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].phase == p) begin
        cpu_addr = vecs[i].addr;
        #1;
        chk($sformatf("p%0d_mem[%0d]", p, vecs[i].addr), cpu_q, vecs[i].q);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 64; a++) begin
      cpu_addr = 6'(a);
      #1;
      chk($sformatf("%s_mem[%0d]", tag, a), cpu_q, 32'h0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vecs[0]  = '{1, 6'd0,  32'h8b1e03c5};
    vecs[1]  = '{1, 6'd1,  32'h8b0400a5};
    vecs[2]  = '{1, 6'd2,  32'h00000000};
    vecs[3]  = '{1, 6'd63, 32'h00000000};
    vecs[4]  = '{2, 6'd0,  32'h00000045};
    vecs[5]  = '{2, 6'd1,  32'h8b0400a5};
    vecs[6]  = '{2, 6'd2,  32'h00000000};
    vecs[7]  = '{3, 6'd0,  32'h03020100};
    vecs[8]  = '{3, 6'd1,  32'h07060504};
    vecs[9]  = '{3, 6'd62, 32'hfbfaf9f8};
    vecs[10] = '{3, 6'd63, 32'hfffefdfc};
    vecs[11] = '{4, 6'd0,  32'h03020100};
    vecs[12] = '{4, 6'd63, 32'hfffefdfc};
    vecs[13] = '{4, 6'd2,  32'h0b0a0908};
    vecs[14] = '{4, 6'd31, 32'h7f7e7d7c};

    reset      = 1'b1;
    cpu_addr   = '0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_byte  = '0;
    load_end   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    check_all_zero("rst");

    // Two full words, load_end on the byte that completes the second word
    start_load();
    chk("l1_ready", 32'(load_ready), 32'd1);
    chk("l1_stall", 32'(cpu_stall), 32'd1);
    send(8'hc5, 1'b0); send(8'h03, 1'b0); send(8'h1e, 1'b0); send(8'h8b, 1'b0);
    send(8'ha5, 1'b0); send(8'h00, 1'b0); send(8'h04, 1'b0); send(8'h8b, 1'b1);
    chk("l1_done", 32'(load_done), 32'd1);
    chk("l1_ready_off", 32'(load_ready), 32'd0);
    chk("l1_stall_flush", 32'(cpu_stall), 32'd1);
    tick();
    chk("l1_done_off", 32'(load_done), 32'd0);
    chk("l1_stall_off", 32'(cpu_stall), 32'd0);
    chk("l1_wc", 32'(word_count), 32'd2);
    check_phase(1);

    // Partial word with gaps, then load_end alone
    start_load();
    cpu_addr = 6'd1;
    #1;
    chk("l2_q_masked", cpu_q, 32'h0);
    send(8'h45, 1'b0); tick();
    send(8'h00, 1'b0); tick(); tick();
    send(8'h00, 1'b0); tick();
    chk("l2_no_done_yet", 32'(load_done), 32'd0);
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
    chk("l2_done", 32'(load_done), 32'd1);
    tick();
    chk("l2_stall_off", 32'(cpu_stall), 32'd0);
    chk("l2_wc", 32'(word_count), 32'd1);
    check_phase(2);

    // Fill the whole memory; stop accepting after byte 256
    start_load();
    for (int i = 0; i < 256; i++) send(8'(i), 1'b0);
    chk("l3_ready_off", 32'(load_ready), 32'd0);
    chk("l3_done", 32'(load_done), 32'd1);
    send(8'haa, 1'b0);
    chk("l3_stall_off", 32'(cpu_stall), 32'd0);
    chk("l3_wc", 32'(word_count), 32'd64);
    check_phase(3);

    // Stray valid/end in RUN without load_start
    send(8'haa, 1'b1);
    chk("l4_stall", 32'(cpu_stall), 32'd0);
    chk("l4_done", 32'(load_done), 32'd0);
    chk("l4_ready", 32'(load_ready), 32'd0);
    tick();
    chk("l4_done2", 32'(load_done), 32'd0);
    chk("l4_wc", 32'(word_count), 32'd64);
    check_phase(4);

    // Reset after 5 bytes of a load
    start_load();
    for (int i = 0; i < 5; i++) send(8'(8'h11 * (i + 1)), 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("l5_stall", 32'(cpu_stall), 32'd0);
    chk("l5_ready", 32'(load_ready), 32'd0);
    chk("l5_done", 32'(load_done), 32'd0);
    chk("l5_wc", 32'(word_count), 32'd0);
    tick();
    chk("l5_done2", 32'(load_done), 32'd0);
    check_all_zero("l5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writable 64-word instruction memory with a byte-stream program loader, replacing the fixed-content instruction ROM in the single-cycle LEGv8 core.
- Arbitrates the storage between the CPU fetch port (read) and a host load port (write).
- Sequences loading with an FSM and stalls the CPU while a program is being written.

Parameters:
- N, 32, instruction word width; must be a multiple of 8.
- AW, 6, address width; depth = 2**AW words (64).

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- reset, input, 1, synchronous active-high reset.
- cpu_addr, input, AW, fetch word address (PC[AW+1:2] from core).
- cpu_q, output, N, fetched instruction.
- cpu_stall, output, 1, core must hold PC and suppress writeback while high.
- load_start, input, 1, single-cycle request to begin loading a program.
- load_valid, input, 1, load_byte is valid this cycle.
- load_byte, input, 8, program byte, little-endian within each word.
- load_end, input, 1, host signals last byte; may coincide with load_valid.
- load_ready, output, 1, loader accepts a byte this cycle.
- load_done, output, 1, one-cycle pulse when a load completes.
- word_count, output, AW+1, number of words written by the last load (0..2**AW).

Behaviour:
- Reset:
  - state=RUN; all 2**AW words cleared to 0; byte_idx=0; waddr=0.
  - Assembly register = 0; word_count=0.
  - cpu_stall=0, load_ready=0, load_done=0.
- Byte transfer: occurs on a rising edge where load_valid && load_ready. No other condition writes memory.
- RUN:
  - cpu_q = mem[cpu_addr], combinational, zero-latency (same timing as the previous ROM).
  - cpu_stall=0; load_ready=0; load_valid and load_end ignored.
  - On load_start: next state LOAD; byte_idx, waddr, word_count and the assembly register all cleared.
- LOAD:
  - cpu_stall=1; cpu_q=0; load_ready=1; load_start ignored.
  - On transfer: load_byte stored in assembly bits [8*byte_idx+7 : 8*byte_idx], then byte_idx incremented.
  - Transfer with byte_idx==N/8-1: completed word, including the current byte, written to mem[waddr] on the same edge. Then waddr increments, word_count increments, byte_idx returns to 0, assembly register clears.
  - Word written at waddr==2**AW-1: word_count becomes 2**AW and next state is FLUSH. Further bytes are not accepted; there is no wrap-around.
  - load_end (with or without a transfer that cycle):
    - If a partial word is pending, including the byte just accepted, it is written with unfilled upper bytes = 0 and word_count increments.
    - Next state FLUSH.
  - load_end with byte_idx==0 and no transfer: nothing is written.
  - Words at or above the final waddr keep their previous contents.
- FLUSH (1 cycle):
  - load_done=1; cpu_stall=1; load_ready=0; cpu_q=0.
  - Next state RUN; cpu_stall deasserts on that edge.
- Simultaneous events:
  - load_start and load_end in RUN: start wins; load_end ignored.
  - Full word completed and load_end on the same edge: word written once, next state FLUSH.
- Reset mid-load: returns to RUN immediately; all memory cleared; no load_done pulse.
- Total latency: load_start to first accept is 1 cycle. The last accepted byte to load_done is 1 cycle. load_done to stall release is 1 cycle.

Test Plan:
- Reset then RUN with cpu_addr 0..63 -> cpu_q=0 for every address; cpu_stall=0, load_ready=0.
- load_start, then bytes c5 03 1e 8b a5 00 04 8b with load_end on the last byte:
  - mem[0]=8b1e03c5 and mem[1]=8b0400a5.
  - word_count=2; load_done pulses 1 cycle after the last byte; stall drops 1 cycle later.
- Load bytes 45 00 00 then load_end alone, with load_valid gaps between the bytes -> mem[0]=00000045, word_count=1, mem[1..63] unchanged.
- Stream 256 bytes (0x00..0xFF):
  - mem[63]=fffefdfc, word_count=64.
  - load_ready drops after byte 256 and further load_valid is ignored.
  - mem[0]=03020100.
- Assert reset after 5 bytes of a load -> next cycle state RUN, all cpu_q=0, load_done never pulses, word_count=0.
- In RUN, pulse load_valid=1 with load_byte=aa and load_end=1 (no load_start) -> memory unchanged, no load_done, cpu_stall stays 0.
